rms_sumsq_accum: RTL and testbench
==================================

Name: rms_sumsq_accum

Overview:
- Front end of the RMS datapath. Squares a stream of signed samples and accumulates the squares over a programmable window of N samples.
- At window close, emits the sum of squares and N as a one-cycle-valid pair. The pair feeds the pipelined divider's numerator (72 b) and denominator (8 b) inputs directly.
- Three-stage pipeline with no back-pressure. Accepts one sample per clock.

Parameters:
- SAMPLE_WIDTH, 32, signed two's-complement sample width
- SQUARE_WIDTH, 64, unsigned square width; must equal 2*SAMPLE_WIDTH
- COUNT_WIDTH, 8, window length / count width; max window 2^COUNT_WIDTH-1
- SUM_WIDTH, 72, accumulator width; must be >= SQUARE_WIDTH+COUNT_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sample_in  in  SAMPLE_WIDTH  signed sample
- sample_valid_in  in  1  sample_in is valid this cycle
- window_len_in  in  COUNT_WIDTH  window length N; used only for the first sample of a window
- clear_in  in  1  synchronous abort: flush pipeline, discard partial window
- sum_out  out  SUM_WIDTH  sum of squares of the completed window
- count_out  out  COUNT_WIDTH  N of the completed window
- valid_out  out  1  one-cycle pulse: sum_out/count_out are new

Behaviour:
- Reset (rst=0, async): all pipeline registers, valids, accumulator and counter go to 0. sum_out=0, count_out=0, valid_out=0. State is held until rst=1.
- S0, edge E0: capture sample_in, window_len_in and sample_valid_in.
- S1, edge E0+1: square = sample*sample, unsigned SQUARE_WIDTH. Carry the valid bit and window_len.
- S2, edge E0+2: accumulate. Per-window counter cnt and latched length len_q.
  - If cnt==0 (window start): len_q <= carried window_len; acc <= zero-extended square; cnt <= 1.
  - Otherwise: acc <= acc + square; cnt <= cnt+1.
  - Window close when (cnt==0 ? window_len : len_q) equals the post-update count:
    - sum_out <= final acc (acc+square or square); count_out <= len_q/window_len; valid_out <= 1.
    - cnt <= 0.
- Latency: valid_out is visible after edge E0+2, where E0 captured the final sample.
- Output hold: valid_out is high for exactly one cycle. sum_out/count_out hold their values until the next valid_out.
- Gaps: cycles with the valid bit low leave acc and cnt untouched. A window may span any number of idle cycles.
- Back-to-back windows: the next window's first sample may follow the closing sample with no bubble. Its square loads acc directly; there is no dependency on the old acc.
- N=1: every valid sample produces valid_out with sum=square, count=1.
- N=0 at window start: the sample is discarded, no state change, no output. The next valid sample re-evaluates window_len.
- window_len_in changes mid-window are ignored; only len_q is used.
- Width: max sum = (2^COUNT_WIDTH-1)*2^(2*SAMPLE_WIDTH-2) < 2^SUM_WIDTH, so no overflow is possible. Square of the most negative sample is 2^62, representable.
- clear_in=1 (synchronous):
  - At the next edge: S0/S1 valids <= 0, cnt <= 0, acc <= 0, valid_out <= 0.
  - sum_out/count_out keep their last values.
  - A sample presented in the same cycle is dropped (clear wins).
  - A window completing in S2 on that edge is discarded.
- Async reset mid-window: partial window is lost. No valid_out is produced until a full new window completes.

Decomposition:
- Package rms_pkg: SAMPLE_WIDTH, SQUARE_WIDTH, COUNT_WIDTH, SUM_WIDTH constants, shared with the divider instantiation (numerator=SUM_WIDTH, denominator=COUNT_WIDTH).
- One sub-module, rms_square_stage: S0+S1 register pair (sample, valid, window_len in; square, valid, window_len out), with reset/clear.
- Accumulator, counter and output registers stay in the top.

Test Plan:
- N=4, samples 1,-2,3,-4 on consecutive cycles -> one valid_out pulse 2 edges after the last capture; sum_out=30, count_out=4.
- N=255, all samples -2147483648 -> sum_out=0x3F_C000_0000_0000_0000, count_out=255, no overflow.
- N=2, back-to-back samples 3,3,5,5 -> pulses at sum=18 then sum=50, exactly 2 cycles apart, both with count=2.
- N=3 with idle gaps, samples 2,(idle x5),2,(idle),2 and window_len_in changed to 7 after the first sample -> sum_out=12, count_out=3.
- N=4: two samples, clear_in pulse, then 4 samples of 1 -> only one valid_out, sum_out=4.
- N=4: async rst low mid-window -> all outputs 0 immediately. N=0 with samples presented -> no valid_out. rst released, N=1, sample -7 -> sum_out=49, count_out=1.

Source files
------------

// File: rtl/rms_pkg.sv
// Shared widths for the RMS datapath: the sum-of-squares front end and the
// divider it feeds (numerator = SUM_WIDTH, denominator = COUNT_WIDTH).
package rms_pkg;

  localparam int SAMPLE_WIDTH = 32;
  localparam int SQUARE_WIDTH = 2 * SAMPLE_WIDTH;
  localparam int COUNT_WIDTH  = 8;
  localparam int SUM_WIDTH    = 72;

endpackage

// File: rtl/rms_square_stage.sv
// S0 capture register and S1 squarer register. The valid bit and the window
// length ride along with the data so the accumulator sees them aligned.
module rms_square_stage #(
  parameter int SAMPLE_WIDTH = rms_pkg::SAMPLE_WIDTH,
  parameter int SQUARE_WIDTH = rms_pkg::SQUARE_WIDTH,
  parameter int COUNT_WIDTH  = rms_pkg::COUNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  input  logic [COUNT_WIDTH-1:0]  window_len,
  output logic [SQUARE_WIDTH-1:0] square,
  output logic                    square_valid,
  output logic [COUNT_WIDTH-1:0]  square_len
);

  logic signed [SAMPLE_WIDTH-1:0] s0_sample;
  logic                           s0_valid;
  logic [COUNT_WIDTH-1:0]         s0_len;
  logic signed [SQUARE_WIDTH-1:0] s0_ext;
  logic signed [SQUARE_WIDTH-1:0] s0_square;

  // Sign-extend before multiplying so the full-width product is exact;
  // the most negative sample squares to 2^62, still positive in 64 bits.
  assign s0_ext    = SQUARE_WIDTH'(s0_sample);
  assign s0_square = s0_ext * s0_ext;

  // NOTE: every flop here, data included, is reset so the outputs are
  // deterministic straight out of reset; this stage holds no memory arrays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_sample    <= '0;
      s0_valid     <= 1'b0;
      s0_len       <= '0;
      square       <= '0;
      square_valid <= 1'b0;
      square_len   <= '0;
    end else begin
      s0_sample    <= sample;
      s0_len       <= window_len;
      square       <= s0_square;
      square_len   <= s0_len;
      s0_valid     <= sample_valid & ~clear;
      square_valid <= s0_valid & ~clear;
    end
  end

endmodule

// File: rtl/rms_sumsq_accum.sv
// Sum-of-squares accumulator over a programmable window of N samples.
// Three stages: capture, square, accumulate; emits {sum, N} as a one-cycle pulse.
module rms_sumsq_accum #(
  parameter int SAMPLE_WIDTH = rms_pkg::SAMPLE_WIDTH,
  parameter int SQUARE_WIDTH = rms_pkg::SQUARE_WIDTH,
  parameter int COUNT_WIDTH  = rms_pkg::COUNT_WIDTH,
  parameter int SUM_WIDTH    = rms_pkg::SUM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  input  logic [COUNT_WIDTH-1:0]  window_len_in,
  input  logic                    clear_in,
  output logic [SUM_WIDTH-1:0]    sum_out,
  output logic [COUNT_WIDTH-1:0]  count_out,
  output logic                    valid_out
);

  logic [SQUARE_WIDTH-1:0] sq;
  logic                    sq_valid;
  logic [COUNT_WIDTH-1:0]  sq_len;

  rms_square_stage #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .SQUARE_WIDTH (SQUARE_WIDTH),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) u_square (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear_in),
    .sample       (sample_in),
    .sample_valid (sample_valid_in),
    .window_len   (window_len_in),
    .square       (sq),
    .square_valid (sq_valid),
    .square_len   (sq_len)
  );

  logic [SUM_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] len_q;

  logic                   start;
  logic [COUNT_WIDTH-1:0] eff_len;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic [SUM_WIDTH-1:0]   acc_sum;
  logic                   take;
  logic                   close;

  // A window start loads the square directly, so back-to-back windows never
  // depend on the previous accumulator value.
  always_comb begin
    start   = (cnt == '0);
    eff_len = start ? sq_len : len_q;
    cnt_inc = cnt + COUNT_WIDTH'(1);
    acc_sum = start ? SUM_WIDTH'(sq) : acc + SUM_WIDTH'(sq);
    take    = sq_valid && (eff_len != '0);
    close   = take && (cnt_inc == eff_len);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      sum_out   <= '0;
      count_out <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (clear_in) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= acc_sum;
        if (start) len_q <= sq_len;
        if (close) begin
          cnt       <= '0;
          sum_out   <= acc_sum;
          count_out <= eff_len;
          valid_out <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rms_sumsq_accum.sv
// Scoreboard bench for rms_sumsq_accum: expected {sum, count, cycle} entries are
// queued when the closing sample is driven and popped on each valid_out pulse.
module tb_rms_sumsq_accum;

  localparam int SW = 32;
  localparam int CW = 8;
  localparam int UW = 72;

  typedef struct {
    logic [UW-1:0] sum;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid_in = 1'b0;
  logic [CW-1:0] window_len_in = '0;
  logic          clear_in = 1'b0;
  logic [UW-1:0] sum_out;
  logic [CW-1:0] count_out;
  logic          valid_out;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  rms_sumsq_accum dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .window_len_in   (window_len_in),
    .clear_in        (clear_in),
    .sum_out         (sum_out),
    .count_out       (count_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every pulse must match the head of the scoreboard, on the right cycle.
  always @(negedge clk) begin
    if (rst && valid_out) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d sum=%0h count=%0d, none expected",
                 cyc, sum_out, count_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_assert++;
        if (sum_out !== e.sum) begin
          n_fail++;
          $display("FAIL sum: got %0h expected %0h", sum_out, e.sum);
        end
        n_assert++;
        if (count_out !== e.cnt) begin
          n_fail++;
          $display("FAIL count: got %0d expected %0d", count_out, e.cnt);
        end
        n_assert++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL latency: pulse at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push(input logic [UW-1:0] s, input logic [CW-1:0] c, input int at);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Presents one valid sample; cap is the edge index that captures it.
  task automatic send(input logic signed [SW-1:0] s, input logic [CW-1:0] n, output int cap);
    @(negedge clk);
    sample_in       = s;
    sample_valid_in = 1'b1;
    window_len_in   = n;
    cap             = cyc + 1;
  endtask

  task automatic idle(input int k, input logic [CW-1:0] n);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      sample_valid_in = 1'b0;
      window_len_in   = n;
    end
  endtask

  task automatic clear_pulse(input logic with_sample);
    @(negedge clk);
    clear_in        = 1'b1;
    sample_valid_in = with_sample;
    sample_in       = 32'd9;
    @(negedge clk);
    clear_in        = 1'b0;
    sample_valid_in = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d pulses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_assert++;
    if (sum_out !== '0) begin n_fail++; $display("FAIL reset_sum: got %0h expected 0", sum_out); end
    n_assert++;
    if (count_out !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    n_assert++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int c;
    send(1, 4, c);
    send(-2, 4, c);
    send(3, 4, c);
    send(-4, 4, c);
    push(72'd30, 8'd4, c + 2);
    idle(1, 4);
    drain("basic", 20);
  endtask

  task automatic test_max_window();
    int c;
    for (int i = 0; i < 255; i++) send(32'sh8000_0000, 255, c);
    push(72'h3F_C000_0000_0000_0000, 8'd255, c + 2);
    idle(1, 255);
    drain("max_window", 20);
  endtask

  task automatic test_back_to_back();
    int c;
    send(3, 2, c);
    send(3, 2, c);
    push(72'd18, 8'd2, c + 2);
    send(5, 2, c);
    send(5, 2, c);
    push(72'd50, 8'd2, c + 2);
    idle(1, 2);
    drain("back_to_back", 20);
  endtask

  task automatic test_gaps();
    int c;
    send(2, 3, c);
    idle(5, 7);
    send(2, 7, c);
    idle(1, 7);
    send(2, 7, c);
    push(72'd12, 8'd3, c + 2);
    idle(1, 7);
    drain("gaps", 20);
  endtask

  task automatic test_clear();
    int c;
    send(5, 4, c);
    send(6, 4, c);
    clear_pulse(1'b1);
    for (int i = 0; i < 4; i++) send(1, 4, c);
    push(72'd4, 8'd4, c + 2);
    idle(1, 4);
    drain("clear", 20);
    // A single-sample window closing on the clear edge must vanish.
    send(3, 1, c);
    idle(1, 1);
    clear_pulse(1'b0);
    idle(4, 1);
    n_assert++;
    if (sum_out !== 72'd4) begin n_fail++; $display("FAIL clear_hold_sum: got %0h expected 4", sum_out); end
    n_assert++;
    if (count_out !== 8'd4) begin n_fail++; $display("FAIL clear_hold_count: got %0d expected 4", count_out); end
    drain("clear_discard", 10);
  endtask

  task automatic test_async_reset();
    int c;
    send(5, 4, c);
    send(6, 4, c);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_assert++;
    if (sum_out !== '0) begin n_fail++; $display("FAIL async_sum: got %0h expected 0", sum_out); end
    n_assert++;
    if (count_out !== '0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", count_out); end
    n_assert++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b expected 0", valid_out); end
    idle(3, 4);
    n_assert++;
    if (sum_out !== '0) begin n_fail++; $display("FAIL async_held_sum: got %0h expected 0", sum_out); end
    @(negedge clk);
    rst = 1'b1;
    send(11, 0, c);
    send(-3, 0, c);
    idle(4, 0);
    send(-7, 1, c);
    push(72'd49, 8'd1, c + 2);
    idle(1, 1);
    drain("async_reset", 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_window();
    test_back_to_back();
    test_gaps();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
